rr_lock_arbiter: RTL and testbench
==================================

Name: rr_lock_arbiter

Overview:
- N-way round-robin arbiter with grant locking, for sharing one resource (bus, memory port, datapath unit) between requesters.
- A winner keeps its grant across a multi-cycle transaction until it signals done, drops its request, or exceeds a hold limit.
- Generalises the two-requester alternating grant scheme to N requesters, with transaction ownership and starvation protection.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- MAX_HOLD, 16, maximum grant cycles per ownership; 0 disables the limit
- ID_W, $clog2(NUM_REQ), width of grant_id
- CNT_W, $clog2(MAX_HOLD+1), hold counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- request  in  NUM_REQ  per-requester request level
- done  in  NUM_REQ  per-requester end-of-transaction pulse, sampled only from the current owner
- grant  out  NUM_REQ  registered one-hot grant (all-zero when idle)
- grant_valid  out  1  OR of grant, registered
- grant_id  out  ID_W  index of owner; holds last owner when idle
- timeout  out  1  one-cycle pulse: owner was force-released by MAX_HOLD

Behaviour:
- Reset (reset=0, asynchronous):
  - grant=0, grant_valid=0, grant_id=0, timeout=0, state=IDLE, hold_cnt=0.
  - last_winner=NUM_REQ-1, so requester 0 has top priority after reset.
  - Outputs clear immediately on reset assertion, even mid-transaction.
- States: IDLE, BUSY.
- IDLE:
  - If request!=0 at edge k, pick the first set bit searching cyclically from last_winner+1.
  - After edge k: grant=onehot(winner), grant_id=winner, grant_valid=1, last_winner=winner, hold_cnt=0, state=BUSY.
  - Latency is one cycle from request to grant. If request==0, stay in IDLE with grant=0.
- BUSY: at each edge, with o = owner, evaluate in this priority order:
  1. done[o]=1 or request[o]=0 -> release.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1 -> forced release; timeout=1 for the following cycle.
  3. Otherwise keep the grant and increment hold_cnt.
- Release: the next cycle has grant=0, grant_valid=0, state=IDLE. Exactly one dead cycle separates consecutive owners. Re-arbitration happens at the edge after that.
- An owner holds the grant for at most MAX_HOLD cycles.
- done from a non-owner, or asserted while IDLE, is ignored.
- done and hold-limit in the same cycle: treated as a normal release, no timeout.
- A force-released owner that still requests becomes lowest priority, because last_winner equals that owner.
- Single requester: it is re-granted after each one-cycle gap.
- NUM_REQ requesters all asserted continuously: grants rotate 0,1,2,...,N-1,0,...
- grant is always one-hot or zero. Assertion: $onehot0(grant), and grant_valid == |grant.

Decomposition:
- Package arb_pkg holds:
  - arb_state_t enum {ARB_IDLE, ARB_BUSY}
  - default NUM_REQ/MAX_HOLD constants
  - function onehot_to_idx
- Sub-module rr_pick, purely combinational:
  - inputs: request[NUM_REQ], last_winner[ID_W]
  - outputs: pick_onehot[NUM_REQ], pick_idx[ID_W], pick_valid
  - search is rotate/priority/rotate-back
- rr_lock_arbiter contains the FSM, hold counter and output registers.

Test Plan (NUM_REQ=4, MAX_HOLD=4):
1. Reset with request=4'b1111, release reset -> next edge grant=0001, grant_id=0. Pulse done[0] -> dead cycle, then grant=0010, then 0100, then 1000, then 0001.
2. request=4'b0100 held, no done -> grant=0100 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then grant=0100 again.
3. Owner 1 with request=4'b1010, owner drops request[1] at cycle 2 -> grant=0 next cycle, then grant=1000.
4. Owner 2, done[0] and done[3] pulsed -> grant stays 0100. done[2] together with hold_cnt=3 -> release with timeout=0.
5. Owner 3 at hold_cnt=2, assert reset=0 asynchronously between edges -> grant=0 and grant_valid=0 immediately. After release with request=4'b1001 -> grant=0001.
6. request=0 for 10 cycles -> grant=0, grant_valid=0, grant_id unchanged, timeout=0 throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin lock arbiter.
//   arb_state_t    : FSM encoding (idle / owner holding the grant)
//   DEF_NUM_REQ    : default requester count
//   DEF_MAX_HOLD   : default hold limit in cycles (0 = unlimited)
//   onehot_to_idx  : index of the set bit of a one-hot vector (up to 16 bits)
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ  = 4;
  localparam int DEF_MAX_HOLD = 16;

  // Zero input yields index 0. Callers only use the result when a bit is set.
  function automatic logic [3:0] onehot_to_idx(input logic [15:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   request     : per-requester request levels
//   last_winner : index of the previous winner; search starts one above it
//   pick_onehot : one-hot winner (zero when no request)
//   pick_idx    : index of the winner
//   pick_valid  : at least one request present
module rr_pick
  import arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [ID_W-1:0]    last_winner,
  output logic [NUM_REQ-1:0] pick_onehot,
  output logic [ID_W-1:0]    pick_idx,
  output logic               pick_valid
);

  logic [2*NUM_REQ-1:0] rot_dbl;
  logic [2*NUM_REQ-1:0] back_dbl;
  logic [NUM_REQ-1:0]   rot_req;
  logic [NUM_REQ-1:0]   rot_onehot;
  logic [15:0]          onehot_16;
  logic [3:0]           idx_16;
  int unsigned          shift;

  // Rotate so that last_winner+1 lands at bit 0, take the lowest set bit,
  // then rotate back. Doubling the vector gives a rotate for any NUM_REQ,
  // not just powers of two.
  always_comb begin
    shift      = (32'(last_winner) + 32'd1) % 32'(NUM_REQ);
    rot_dbl    = {request, request} >> shift;
    rot_req    = rot_dbl[NUM_REQ-1:0];
    rot_onehot = rot_req & (~rot_req + 1'b1);
    back_dbl   = {rot_onehot, rot_onehot} << shift;
    pick_onehot = back_dbl[2*NUM_REQ-1:NUM_REQ];
    onehot_16  = '0;
    onehot_16[NUM_REQ-1:0] = pick_onehot;
    idx_16     = onehot_to_idx(onehot_16);
    pick_idx   = idx_16[ID_W-1:0];
    pick_valid = |request;
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking and a hold limit.
//   clk         : rising-edge clock
//   reset       : asynchronous active-low reset
//   request     : per-requester request levels
//   done        : per-requester end-of-transaction pulse (owner's bit only)
//   grant       : registered one-hot grant, zero when idle
//   grant_valid : registered OR of grant
//   grant_id    : owner index; keeps the last owner while idle
//   timeout     : one-cycle pulse after a forced release at MAX_HOLD
// A release always inserts one dead cycle before the next owner is chosen.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  parameter int ID_W     = $clog2(NUM_REQ),
  parameter int CNT_W    = $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               grant_valid,
  output logic [ID_W-1:0]    grant_id,
  output logic               timeout
);

  // With MAX_HOLD=0 the counter is unused but still needs one bit.
  localparam int CNT_WI = (CNT_W < 1) ? 1 : CNT_W;
  localparam logic [CNT_WI-1:0] HOLD_LAST =
    CNT_WI'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_t          state, state_n;
  logic [NUM_REQ-1:0]  grant_n;
  logic                grant_valid_n;
  logic [ID_W-1:0]     grant_id_n;
  logic                timeout_n;
  logic [ID_W-1:0]     last_winner, last_winner_n;
  logic [CNT_WI-1:0]   hold_cnt, hold_cnt_n;

  logic [NUM_REQ-1:0]  pick_onehot;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_valid;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .request     (request),
    .last_winner (last_winner),
    .pick_onehot (pick_onehot),
    .pick_idx    (pick_idx),
    .pick_valid  (pick_valid)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    state_n       = state;
    grant_n       = grant;
    grant_id_n    = grant_id;
    last_winner_n = last_winner;
    hold_cnt_n    = hold_cnt;
    timeout_n     = 1'b0;

    unique case (state)
      ARB_IDLE: begin
        grant_n = '0;
        if (pick_valid) begin
          grant_n       = pick_onehot;
          grant_id_n    = pick_idx;
          last_winner_n = pick_idx;
          hold_cnt_n    = '0;
          state_n       = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A normal release wins over the hold limit, so done on the last
        // allowed cycle does not raise timeout.
        if (done[grant_id] || !request[grant_id]) begin
          grant_n = '0;
          state_n = ARB_IDLE;
        end else if (MAX_HOLD != 0 && hold_cnt == HOLD_LAST) begin
          grant_n   = '0;
          timeout_n = 1'b1;
          state_n   = ARB_IDLE;
        end else begin
          hold_cnt_n = hold_cnt + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase

    grant_valid_n = |grant_n;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ARB_IDLE;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
      timeout     <= 1'b0;
      last_winner <= ID_W'(NUM_REQ - 1);
      hold_cnt    <= '0;
    end else begin
      state       <= state_n;
      grant       <= grant_n;
      grant_valid <= grant_valid_n;
      grant_id    <= grant_id_n;
      timeout     <= timeout_n;
      last_winner <= last_winner_n;
      hold_cnt    <= hold_cnt_n;
    end
  end

  a_grant_onehot : assert property (@(posedge clk) disable iff (!reset)
    $onehot0(grant) && (grant_valid == |grant));

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Directed bench for rr_lock_arbiter with NUM_REQ=4, MAX_HOLD=4.
// Outputs are sampled 1 ns after each rising edge; inputs change there too.
module tb_rr_lock_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int MAX_HOLD = 4;
  localparam int ID_W     = 2;

  logic               clk;
  logic               reset;
  logic [NUM_REQ-1:0] request;
  logic [NUM_REQ-1:0] done;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic [ID_W-1:0]    grant_id;
  logic               timeout;

  int checks;
  int failures;

  rr_lock_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .request     (request),
    .done        (done),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packs {grant, grant_valid, grant_id, timeout}; grant_valid follows grant.
  function automatic logic [7:0] exp_vec(input logic [3:0] g, input logic [1:0] id,
                                         input logic to);
    return {g, |g, id, to};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    request = '0;
    done    = '0;
    reset   = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Reset values, then a full done-driven rotation with all four requesting.
  task automatic test_reset_rotation();
    logic [7:0] obs, exp;
    logic [3:0] seq_g  [4];
    logic [1:0] seq_id [4];
    seq_g  = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    seq_id = '{2'd1, 2'd2, 2'd3, 2'd0};
    request = 4'b1111;
    done    = '0;
    reset   = 1'b0;
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0000, 2'd0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", obs, exp);
    end
    reset = 1'b1;
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0001, 2'd0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL first_grant: got %b expected %b", obs, exp);
    end
    for (int k = 0; k < 4; k++) begin
      done = grant;
      step();
      done = '0;
      obs = {grant, grant_valid, grant_id, timeout};
      exp = exp_vec(4'b0000, (k == 0) ? 2'd0 : seq_id[k-1], 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rotate_gap%0d: got %b expected %b", k, obs, exp);
      end
      step();
      obs = {grant, grant_valid, grant_id, timeout};
      exp = exp_vec(seq_g[k], seq_id[k], 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL rotate_grant%0d: got %b expected %b", k, obs, exp);
      end
    end
  endtask

  // Single requester held without done: 4 grant cycles, timeout gap, regrant.
  task automatic test_hold_limit();
    logic [7:0] obs, exp;
    apply_reset();
    request = 4'b0100;
    for (int c = 0; c < MAX_HOLD; c++) begin
      step();
      obs = {grant, grant_valid, grant_id, timeout};
      exp = exp_vec(4'b0100, 2'd2, 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL hold_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0000, 2'd2, 1'b1);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL hold_timeout: got %b expected %b", obs, exp);
    end
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0100, 2'd2, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL hold_regrant: got %b expected %b", obs, exp);
    end
  endtask

  // Owner 1 drops its request on its second cycle; requester 3 follows.
  task automatic test_request_drop();
    logic [7:0] obs, exp;
    apply_reset();
    request = 4'b1010;
    step();
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0010, 2'd1, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL drop_owner: got %b expected %b", obs, exp);
    end
    request = 4'b1000;
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0000, 2'd1, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL drop_release: got %b expected %b", obs, exp);
    end
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b1000, 2'd3, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL drop_next: got %b expected %b", obs, exp);
    end
  endtask

  // Foreign done ignored; owner's done on the last hold cycle gives no timeout.
  task automatic test_done_filter();
    logic [7:0] obs, exp;
    apply_reset();
    request = 4'b0100;
    step();
    done = 4'b1001;
    step();
    done = '0;
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0100, 2'd2, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL foreign_done: got %b expected %b", obs, exp);
    end
    step();
    step();
    done = 4'b0100;
    step();
    done = '0;
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0000, 2'd2, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL done_at_limit: got %b expected %b", obs, exp);
    end
  endtask

  // Asynchronous reset mid-transaction, then arbitration restarts from 0.
  task automatic test_async_reset();
    logic [7:0] obs, exp;
    apply_reset();
    request = 4'b1000;
    step();
    step();
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b1000, 2'd3, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL pre_reset_owner: got %b expected %b", obs, exp);
    end
    #2;
    reset = 1'b0;
    #1;
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0000, 2'd0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL async_clear: got %b expected %b", obs, exp);
    end
    step();
    request = 4'b1001;
    reset   = 1'b1;
    step();
    obs = {grant, grant_valid, grant_id, timeout};
    exp = exp_vec(4'b0001, 2'd0, 1'b0);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL post_reset_grant: got %b expected %b", obs, exp);
    end
  endtask

  // Idle for 10 cycles after owner 2: grant_id keeps 2, nothing else moves.
  task automatic test_idle();
    logic [7:0] obs, exp;
    request = '0;
    step();
    request = 4'b0100;
    step();
    request = '0;
    step();
    for (int c = 0; c < 10; c++) begin
      step();
      obs = {grant, grant_valid, grant_id, timeout};
      exp = exp_vec(4'b0000, 2'd2, 1'b0);
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL idle_cycle%0d: got %b expected %b", c, obs, exp);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    request  = '0;
    done     = '0;
    test_reset_rotation();
    test_hold_limit();
    test_request_drop();
    test_done_filter();
    test_async_reset();
    test_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
